// File: rtl/tx_pkt_wr_arb_if.sv
// Source/FIFO bundle for the two-source TX packet write arbiter.
`default_nettype none

interface tx_pkt_wr_arb_if #(
  parameter int WIDTH = 256,
  parameter int PTR   = 10,
  parameter int LENW  = 8
);
  logic             src0_req;
  logic [LENW-1:0]  src0_len;
  logic             src0_valid;
  logic [WIDTH-1:0] src0_data;
  logic             src0_eop;
  logic             src0_gnt;
  logic             src0_ack;

  logic             src1_req;
  logic [LENW-1:0]  src1_len;
  logic             src1_valid;
  logic [WIDTH-1:0] src1_data;
  logic             src1_eop;
  logic             src1_gnt;
  logic             src1_ack;

  logic             fifo_wren;
  logic [WIDTH-1:0] fifo_datain;
  logic             fifo_wrfull;
  logic [PTR-1:0]   fifo_wrusedw;
  logic             pkt_err;

  // arbiter side
  modport slave (
    input  src0_req, src0_len, src0_valid, src0_data, src0_eop,
    input  src1_req, src1_len, src1_valid, src1_data, src1_eop,
    input  fifo_wrfull, fifo_wrusedw,
    output src0_gnt, src0_ack, src1_gnt, src1_ack,
    output fifo_wren, fifo_datain, pkt_err
  );

  // sources + FIFO side
  modport master (
    output src0_req, src0_len, src0_valid, src0_data, src0_eop,
    output src1_req, src1_len, src1_valid, src1_data, src1_eop,
    output fifo_wrfull, fifo_wrusedw,
    input  src0_gnt, src0_ack, src1_gnt, src1_ack,
    input  fifo_wren, fifo_datain, pkt_err
  );
endinterface

`default_nettype wire

// File: rtl/tx_pkt_wr_arb.sv
// Round-robin arbiter writing whole packets from two sources into one TX FIFO.
// A source is only granted when its full packet length fits in the free space.
`default_nettype none

module tx_pkt_wr_arb #(
  parameter int WIDTH = 256,
  parameter int DEPTH = 1024,
  parameter int PTR   = 10,
  parameter int LENW  = 8
) (
  input  logic          clk,
  input  logic          reset_,
  tx_pkt_wr_arb_if.slave bus
);

  localparam int CW = ((PTR + 1) > LENW) ? (PTR + 1) : LENW;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER0 = 2'd1,
    XFER1 = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic             rr, rr_nxt;
  logic [LENW-1:0]  cnt, cnt_nxt;
  logic             pkt_err, pkt_err_nxt;

  logic [PTR:0]     free;
  logic [CW-1:0]    free_x, len0_x, len1_x;
  logic             elig0, elig1;

  logic             sel_valid, sel_eop, acc, len_hit, end_beat;
  logic [LENW-1:0]  sel_len, cnt_inc;
  logic [WIDTH-1:0] datain;
  logic             wren, ack0, ack1;

  assign free   = (PTR + 1)'(DEPTH) - {1'b0, bus.fifo_wrusedw};
  assign free_x = CW'(free);
  assign len0_x = CW'(bus.src0_len);
  assign len1_x = CW'(bus.src1_len);
  assign elig0  = bus.src0_req & (len0_x <= free_x) & ~bus.fifo_wrfull;
  assign elig1  = bus.src1_req & (len1_x <= free_x) & ~bus.fifo_wrfull;

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state   <= IDLE;
      rr      <= 1'b0;
      cnt     <= '0;
      pkt_err <= 1'b0;
    end else begin
      state   <= state_nxt;
      rr      <= rr_nxt;
      cnt     <= cnt_nxt;
      pkt_err <= pkt_err_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    rr_nxt      = rr;
    cnt_nxt     = cnt;
    pkt_err_nxt = 1'b0;
    sel_valid   = 1'b0;
    sel_eop     = 1'b0;
    sel_len     = '0;
    datain      = '0;
    acc         = 1'b0;
    len_hit     = 1'b0;
    end_beat    = 1'b0;
    wren        = 1'b0;
    ack0        = 1'b0;
    ack1        = 1'b0;
    cnt_inc     = cnt + 1'b1;

    case (state)
      IDLE: begin
        cnt_nxt = '0;
        // rr=1 means src1 was not served last and wins a tie
        if (elig0 && (!elig1 || !rr)) begin
          state_nxt = XFER0;
        end else if (elig1) begin
          state_nxt = XFER1;
        end
      end
      XFER0: begin
        sel_valid = bus.src0_valid;
        sel_eop   = bus.src0_eop;
        sel_len   = bus.src0_len;
        datain    = bus.src0_data;
      end
      XFER1: begin
        sel_valid = bus.src1_valid;
        sel_eop   = bus.src1_eop;
        sel_len   = bus.src1_len;
        datain    = bus.src1_data;
      end
      default: state_nxt = IDLE;
    endcase

    if (state == XFER0 || state == XFER1) begin
      acc      = sel_valid & ~bus.fifo_wrfull;
      len_hit  = (cnt_inc == sel_len);
      end_beat = acc & (sel_eop | len_hit);
      wren     = acc;
      ack0     = acc & (state == XFER0);
      ack1     = acc & (state == XFER1);
      if (acc) begin
        cnt_nxt = cnt_inc;
      end
      if (end_beat) begin
        state_nxt   = IDLE;
        rr_nxt      = (state == XFER0);
        pkt_err_nxt = sel_eop ^ len_hit;
      end
    end
  end

  assign bus.src0_gnt    = (state == XFER0);
  assign bus.src1_gnt    = (state == XFER1);
  assign bus.src0_ack    = ack0;
  assign bus.src1_ack    = ack1;
  assign bus.fifo_wren   = wren;
  assign bus.fifo_datain = datain;
  assign bus.pkt_err     = pkt_err;

endmodule

`default_nettype wire
